// File: rtl/baccarat_dealer_fsm.sv
// Baccarat dealer control: sequences card-load strobes, applies third-card rules, drives win lights.
// Optional BACCARAT_AUTO_RESTART_EN: leave DONE after HOLD_CYCLES cycles and deal a new round.
module baccarat_dealer_fsm #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       round_done
);

  typedef enum logic [3:0] {
    StP1, StD1, StP2, StD2, StEval, StP3, StBank, StD3, StDone
  } state_e;

  state_e state_q, state_d;

  logic [3:0] ps_sat, ds_sat, p3_val;
  logic       banker_draw;
  logic       done_exit;

  // Out-of-range scores compare as 9; face cards and tens are worth 0.
  assign ps_sat = (pscore > 4'd9) ? 4'd9 : pscore;
  assign ds_sat = (dscore > 4'd9) ? 4'd9 : dscore;
  assign p3_val = (pcard3 >= 4'd10) ? 4'd0 : pcard3;

  always_comb begin
    banker_draw = 1'b0;
    case (ds_sat)
      4'd0, 4'd1, 4'd2: banker_draw = 1'b1;
      4'd3:             banker_draw = (p3_val != 4'd8);
      4'd4:             banker_draw = (p3_val >= 4'd2) && (p3_val <= 4'd7);
      4'd5:             banker_draw = (p3_val >= 4'd4) && (p3_val <= 4'd7);
      4'd6:             banker_draw = (p3_val >= 4'd6) && (p3_val <= 4'd7);
      default:          banker_draw = 1'b0;
    endcase
  end

`ifdef BACCARAT_AUTO_RESTART_EN
  localparam int unsigned HoldMin = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam int unsigned CntW    = (HoldMin < 2) ? 1 : $clog2(HoldMin);

  logic [CntW-1:0] hold_cnt_q;

  // Held at zero outside DONE, so it is cleared on every DONE entry.
  always_ff @(posedge slow_clock) begin
    if (reset || (state_q != StDone)) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_q + 1'b1;
    end
  end

  assign done_exit = (hold_cnt_q == CntW'(HoldMin - 1));
`else
  assign done_exit = 1'b0;
`endif

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state_q <= StP1;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StP1;
    case (state_q)
      StP1:   state_d = StD1;
      StD1:   state_d = StP2;
      StP2:   state_d = StD2;
      StD2:   state_d = StEval;
      StEval: begin
        if ((ps_sat >= 4'd8) || (ds_sat >= 4'd8)) state_d = StDone;
        else if (ps_sat <= 4'd5)                  state_d = StP3;
        else if (ds_sat <= 4'd5)                  state_d = StD3;
        else                                      state_d = StDone;
      end
      StP3:   state_d = StBank;
      StBank: state_d = banker_draw ? StD3 : StDone;
      StD3:   state_d = StDone;
      StDone: state_d = done_exit ? StP1 : StDone;
      default: state_d = StP1;
    endcase
  end

  // Moore outputs, forced low while reset is asserted.
  always_comb begin
    load_pcard1      = 1'b0;
    load_pcard2      = 1'b0;
    load_pcard3      = 1'b0;
    load_dcard1      = 1'b0;
    load_dcard2      = 1'b0;
    load_dcard3      = 1'b0;
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;
    round_done       = 1'b0;
    if (!reset) begin
      case (state_q)
        StP1:   load_pcard1 = 1'b1;
        StD1:   load_dcard1 = 1'b1;
        StP2:   load_pcard2 = 1'b1;
        StD2:   load_dcard2 = 1'b1;
        StP3:   load_pcard3 = 1'b1;
        StD3:   load_dcard3 = 1'b1;
        StDone: begin
          round_done       = 1'b1;
          player_win_light = (ps_sat >= ds_sat);
          dealer_win_light = (ds_sat >= ps_sat);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_baccarat_dealer_fsm.sv
// Randomized scoreboard bench for baccarat_dealer_fsm; expected outputs come from a round-level model.
module tb_baccarat_dealer_fsm;

  localparam int unsigned Hold = 4;

  logic       slow_clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] pscore = '0, dscore = '0, pcard3 = '0;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light, round_done;

  baccarat_dealer_fsm #(.HOLD_CYCLES(Hold)) dut (
    .slow_clock       (slow_clock),
    .reset            (reset),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light),
    .round_done       (round_done)
  );

  always #5 slow_clock = ~slow_clock;

  // Vector layout: {lp1, ld1, lp2, ld2, lp3, ld3, pwin, dwin, done}
  localparam logic [8:0] VP1 = 9'b100000000;
  localparam logic [8:0] VD1 = 9'b010000000;
  localparam logic [8:0] VP2 = 9'b001000000;
  localparam logic [8:0] VD2 = 9'b000100000;
  localparam logic [8:0] VP3 = 9'b000010000;
  localparam logic [8:0] VD3 = 9'b000001000;
  localparam logic [8:0] VNone = 9'b000000000;

  logic [8:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic int sat9(input int s);
    return (s > 9) ? 9 : s;
  endfunction

  function automatic int card_value(input int code);
    return (code >= 10) ? 0 : code;
  endfunction

  // Banker's draw table, written as the casino rule reads.
  function automatic bit banker_draws(input int bank, input int v);
    if (bank <= 2) return 1'b1;
    if (bank == 3) return v != 8;
    if (bank == 4) return (v >= 2) && (v <= 7);
    if (bank == 5) return (v >= 4) && (v <= 7);
    if (bank == 6) return (v >= 6) && (v <= 7);
    return 1'b0;
  endfunction

  task automatic step(input logic rst, input int ps, input int ds, input int pc,
                      input logic [8:0] exp);
    @(posedge slow_clock);
    #1;
    reset  = rst;
    pscore = 4'(ps);
    dscore = 4'(ds);
    pcard3 = 4'(pc);
    exp_q.push_back(exp);
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b1, $urandom_range(0, 15), $urandom_range(0, 15),
                                     $urandom_range(0, 13), VNone);
  endtask

  // Scores ps0/ds0 hold through the last decision; ps1/ds1 are the final scores shown in DONE.
  task automatic run_round(input int ps0, input int ds0, input int pc, input int ps1,
                           input int ds1, input int abort_at);
    logic [8:0] seq[$];
    int p = sat9(ps0);
    int d = sat9(ds0);
    int last_dec = 4;
    int fp = sat9(ps1);
    int fd = sat9(ds1);
    logic [8:0] done_v;
    int n_done;
    seq = '{VP1, VD1, VP2, VD2, VNone};
    if (p >= 8 || d >= 8) begin
    end else if (p <= 5) begin
      seq.push_back(VP3);
      seq.push_back(VNone);
      last_dec = 6;
      if (banker_draws(d, card_value(pc))) seq.push_back(VD3);
    end else if (d <= 5) begin
      seq.push_back(VD3);
    end
    done_v = {6'b0, fp >= fd, fd >= fp, 1'b1};
`ifdef BACCARAT_AUTO_RESTART_EN
    n_done = Hold;
`else
    n_done = 3;
`endif
    for (int i = 0; i < n_done; i++) seq.push_back(done_v);
`ifdef BACCARAT_AUTO_RESTART_EN
    seq.push_back(VP1);
`endif
    for (int k = 0; k < seq.size(); k++) begin
      if (k == abort_at) begin
        step(1'b1, ps1, ds1, pc, VNone);
        break;
      end
      if (k <= last_dec) step(1'b0, ps0, ds0, pc, seq[k]);
      else               step(1'b0, ps1, ds1, pc, seq[k]);
    end
    reset_cycles($urandom_range(1, 2));
  endtask

  // Monitor: every cycle with a pending expectation is compared at the falling edge.
  initial begin
    logic [8:0] e, act;
    forever begin
      @(negedge slow_clock);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3,
               player_win_light, dealer_win_light, round_done};
        n_cmp++;
        if (act !== e) begin
          n_bad++;
          $display("FAIL outputs at %0t: got %b, expected %b", $time, act, e);
        end
      end
    end
  end

  initial begin
    reset_cycles(2);
    run_round(8, 3, 0, 8, 3, -1);    // natural, player wins
    run_round(4, 3, 13, 4, 7, -1);   // both third cards, dealer wins
    run_round(2, 3, 8, 5, 5, -1);    // banker stands on player 8, tie
    run_round(7, 5, 0, 7, 7, -1);    // player stands, dealer draws, tie
    run_round(6, 6, 0, 6, 6, -1);    // both stand, tie
    run_round(4, 3, 5, 4, 3, 6);     // reset during BANK
    run_round(12, 15, 0, 14, 3, -1); // out-of-range scores saturate
    for (int r = 0; r < 60; r++) begin
      int ab;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_round($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 13),
                $urandom_range(0, 15), $urandom_range(0, 15), ab);
    end
    repeat (3) @(negedge slow_clock);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
